// File: rtl/vdic_mult_seq_if.sv
// Request/acknowledge arithmetic-unit bus for the sequential multiplier.
// The master drives operands and req; the slave returns ack, busy and the result.
interface vdic_mult_seq_if #(
    parameter int WIDTH = 16
);
    logic                   req;
    logic [WIDTH-1:0]       arg_a;
    logic [WIDTH-1:0]       arg_b;
    logic                   arg_a_parity;
    logic                   arg_b_parity;
    logic                   signed_mode;
    logic                   ack;
    logic                   busy;
    logic [2*WIDTH-1:0]     result;
    logic                   result_parity;
    logic                   result_rdy;
    logic                   arg_parity_error;

    modport master (
        output req, arg_a, arg_b, arg_a_parity, arg_b_parity, signed_mode,
        input  ack, busy, result, result_parity, result_rdy, arg_parity_error
    );

    modport slave (
        input  req, arg_a, arg_b, arg_a_parity, arg_b_parity, signed_mode,
        output ack, busy, result, result_parity, result_rdy, arg_parity_error
    );
endinterface

// File: rtl/vdic_mult_seq.sv
// Parity-checked shift-add multiplier, one partial product per clock,
// signed or unsigned per operation, behind a req/ack handshake.
//
// state | meaning
// IDLE  | waiting for req; operands captured on the accepting edge
// MUL   | WIDTH shift-add steps, or one pass-through cycle on parity error
// DONE  | result_rdy pulse; result and error flag held afterwards
module vdic_mult_seq #(
    parameter int WIDTH      = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    vdic_mult_seq_if.slave     bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               state_q;
    logic [CW-1:0]        step_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic                 neg_q;
    logic                 err_q;
    logic                 ack_q;
    logic                 busy_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 result_parity_q;
    logic                 result_rdy_q;
    logic                 arg_parity_error_q;

    logic                 a_neg_d;
    logic                 b_neg_d;
    logic [WIDTH-1:0]     mag_a_d;
    logic [WIDTH-1:0]     mag_b_d;
    logic                 err_d;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   prod_d;
    logic                 last_step_d;

    always_comb begin
        a_neg_d     = bus.signed_mode & bus.arg_a[WIDTH-1];
        b_neg_d     = bus.signed_mode & bus.arg_b[WIDTH-1];
        // Most negative value negates to itself, which read unsigned is 2^(WIDTH-1).
        mag_a_d     = a_neg_d ? (~bus.arg_a + 1'b1) : bus.arg_a;
        mag_b_d     = b_neg_d ? (~bus.arg_b + 1'b1) : bus.arg_b;
        err_d       = ((^bus.arg_a ^ PARITY_ODD) != bus.arg_a_parity) |
                      ((^bus.arg_b ^ PARITY_ODD) != bus.arg_b_parity);
        acc_d       = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod_d      = neg_q ? (~acc_d + 1'b1) : acc_d;
        last_step_d = (step_q == LAST_STEP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= IDLE;
            step_q             <= '0;
            acc_q              <= '0;
            mcand_q            <= '0;
            mplier_q           <= '0;
            neg_q              <= 1'b0;
            err_q              <= 1'b0;
            ack_q              <= 1'b0;
            busy_q             <= 1'b0;
            result_q           <= '0;
            result_parity_q    <= PARITY_ODD;
            result_rdy_q       <= 1'b0;
            arg_parity_error_q <= 1'b0;
        end else begin
            ack_q        <= 1'b0;
            result_rdy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        state_q  <= MUL;
                        busy_q   <= 1'b1;
                        ack_q    <= 1'b1;
                        err_q    <= err_d;
                        neg_q    <= a_neg_d ^ b_neg_d;
                        mcand_q  <= {{WIDTH{1'b0}}, mag_a_d};
                        mplier_q <= mag_b_d;
                        acc_q    <= '0;
                        step_q   <= '0;
                    end
                end
                MUL: begin
                    if (err_q) begin
                        state_q            <= DONE;
                        result_q           <= '0;
                        result_parity_q    <= PARITY_ODD;
                        arg_parity_error_q <= 1'b1;
                        result_rdy_q       <= 1'b1;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        step_q   <= last_step_d ? '0 : step_q + 1'b1;
                        // Final step feeds the sign fix-up straight into the result register.
                        if (last_step_d) begin
                            state_q            <= DONE;
                            result_q           <= prod_d;
                            result_parity_q    <= ^prod_d ^ PARITY_ODD;
                            arg_parity_error_q <= 1'b0;
                            result_rdy_q       <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack              = ack_q;
    assign bus.busy             = busy_q;
    assign bus.result           = result_q;
    assign bus.result_parity    = result_parity_q;
    assign bus.result_rdy       = result_rdy_q;
    assign bus.arg_parity_error = arg_parity_error_q;
endmodule

// File: tb/tb_vdic_mult_seq.sv
// Directed bench for vdic_mult_seq (WIDTH=16, even parity) with hand-computed
// products, handshake timing, back-to-back operation and mid-operation reset.
module tb_vdic_mult_seq;
    localparam int W = 16;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    vdic_mult_seq_if #(.WIDTH(W)) bus ();

    vdic_mult_seq #(.WIDTH(W), .PARITY_ODD(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge with the DUT idle; returns on a negedge with the DUT idle.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sm, input logic bad_pa, input logic bad_pb,
                          input logic [2*W-1:0] exp_res, input logic exp_rp,
                          input logic exp_err, input int exp_lat);
        int cnt;
        bus.arg_a        = a;
        bus.arg_b        = b;
        bus.arg_a_parity = (^a) ^ bad_pa;
        bus.arg_b_parity = (^b) ^ bad_pb;
        bus.signed_mode  = sm;
        bus.req          = 1'b1;
        @(negedge clk);
        chk({tag, ".ack"}, 64'(bus.ack), 64'd1);
        chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
        bus.req          = 1'b0;
        bus.arg_a        = W'($urandom);
        bus.arg_b        = W'($urandom);
        bus.arg_a_parity = 1'($urandom);
        bus.arg_b_parity = 1'($urandom);
        bus.signed_mode  = 1'($urandom);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) chk({tag, ".ack_pulse"}, 64'(bus.ack), 64'd0);
        end while (!bus.result_rdy && cnt < 40);
        chk({tag, ".latency"}, 64'(cnt), 64'(exp_lat));
        chk({tag, ".result"}, 64'(bus.result), 64'(exp_res));
        chk({tag, ".rparity"}, 64'(bus.result_parity), 64'(exp_rp));
        chk({tag, ".perr"}, 64'(bus.arg_parity_error), 64'(exp_err));
        @(negedge clk);
        chk({tag, ".rdy_pulse"}, 64'(bus.result_rdy), 64'd0);
        chk({tag, ".result_hold"}, 64'(bus.result), 64'(exp_res));
    endtask

    initial begin
        int ack_t[3];
        int n_ack;
        int n_rdy;
        int busy_low;
        int rdy_wide;
        logic prev_rdy;

        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.req = 1'b0;
        bus.arg_a = '0;
        bus.arg_b = '0;
        bus.arg_a_parity = 1'b0;
        bus.arg_b_parity = 1'b0;
        bus.signed_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.ack", 64'(bus.ack), 64'd0);
        chk("rst.busy", 64'(bus.busy), 64'd0);
        chk("rst.result", 64'(bus.result), 64'd0);
        chk("rst.rparity", 64'(bus.result_parity), 64'd0);
        chk("rst.rdy", 64'(bus.result_rdy), 64'd0);
        chk("rst.perr", 64'(bus.arg_parity_error), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("s_min_min", 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0, 32'h40000000, 1'b1, 1'b0, W);
        run_op("s_m1_x1",   16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, W);
        run_op("u_ffff_x1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 32'h0000FFFF, 1'b0, 1'b0, W);
        run_op("s_max_min", 16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b0, 32'hC0008000, 1'b1, 1'b0, W);
        run_op("perr_a",    16'h0003, 16'h0002, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1, 1);
        run_op("u_3x2",     16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 32'h00000006, 1'b0, 1'b0, W);
        run_op("u_ffff_sq", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'hFFFE0001, 1'b0, 1'b0, W);
        run_op("s_m3_x5",   16'hFFFD, 16'h0005, 1'b1, 1'b0, 1'b0, 32'hFFFFFFF1, 1'b1, 1'b0, W);
        run_op("perr_b",    16'h0005, 16'h0007, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1, 1);
        run_op("u_x_zero",  16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, W);

        // req held high across three operations
        bus.arg_a = 16'h0002;
        bus.arg_b = 16'h0003;
        bus.arg_a_parity = 1'b1;
        bus.arg_b_parity = 1'b0;
        bus.signed_mode = 1'b1;
        bus.req = 1'b1;
        n_ack = 0;
        n_rdy = 0;
        busy_low = 0;
        rdy_wide = 0;
        prev_rdy = 1'b0;
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            if (bus.ack) begin
                if (n_ack < 3) ack_t[n_ack] = t;
                n_ack++;
                if (n_ack == 3) bus.req = 1'b0;
            end
            if (n_ack >= 1 && n_ack < 3 && !bus.busy) busy_low++;
            if (bus.result_rdy) n_rdy++;
            if (bus.result_rdy && prev_rdy) rdy_wide++;
            prev_rdy = bus.result_rdy;
        end
        chk("b2b.n_ack", 64'(n_ack), 64'd3);
        chk("b2b.n_rdy", 64'(n_rdy), 64'd3);
        chk("b2b.rdy_wide", 64'(rdy_wide), 64'd0);
        chk("b2b.busy_low", 64'(busy_low), 64'd2);
        if (n_ack == 3) begin
            chk("b2b.gap1", 64'(ack_t[1] - ack_t[0]), 64'(W + 2));
            chk("b2b.gap2", 64'(ack_t[2] - ack_t[1]), 64'(W + 2));
        end
        chk("b2b.result", 64'(bus.result), 64'd6);

        // reset 5 cycles into MUL with a nonzero prior result and parity
        run_op("pre_rst", 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0, 32'h40000000, 1'b1, 1'b0, W);
        bus.arg_a = 16'h0101;
        bus.arg_b = 16'h0011;
        bus.arg_a_parity = 1'b0;
        bus.arg_b_parity = 1'b0;
        bus.signed_mode = 1'b0;
        bus.req = 1'b1;
        @(negedge clk);
        chk("abort.ack", 64'(bus.ack), 64'd1);
        bus.req = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort.ack0", 64'(bus.ack), 64'd0);
        chk("abort.busy", 64'(bus.busy), 64'd0);
        chk("abort.result", 64'(bus.result), 64'd0);
        chk("abort.rparity", 64'(bus.result_parity), 64'd0);
        chk("abort.rdy", 64'(bus.result_rdy), 64'd0);
        chk("abort.perr", 64'(bus.arg_parity_error), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n_rdy = 0;
        for (int t = 0; t < 25; t++) begin
            @(negedge clk);
            if (bus.result_rdy) n_rdy++;
        end
        chk("abort.no_rdy", 64'(n_rdy), 64'd0);
        run_op("post_rst", 16'h0101, 16'h0011, 1'b0, 1'b0, 1'b0, 32'h00001111, 1'b0, 1'b0, W);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
